// File: rtl/pool_window_feeder.sv
// pool_window_feeder: turns a row-major feature-map stream into the serial
// 2x2-window element sequence (TL, TR, BL, BR) consumed by the max-pool stage.
// The even row of each row pair is held in a line buffer. Each odd-row pixel
// pair then triggers a four-cycle, gap-free window emission.
module pool_window_feeder #(
    parameter int bits     = 16,
    parameter int map_w    = 8,
    parameter int map_h    = 8,
    parameter int col_bits = 3,
    parameter int row_bits = 3
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [bits-1:0] data_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [bits-1:0] data_out,
    output logic            start,
    output logic            out_valid,
    output logic            frame_done
);

    typedef enum logic [1:0] {
        FILL_TOP,
        FILL_BOT,
        EMIT
    } state_t;

    localparam logic [col_bits-1:0] COL_LAST = col_bits'(map_w - 1);
    localparam logic [row_bits-1:0] ROW_LAST = row_bits'(map_h - 1);

    state_t              state_q, state_d;
    logic [col_bits-1:0] col_q, col_d;
    logic [row_bits-1:0] row_q, row_d;
    logic [1:0]          e_q, e_d;
    logic [bits-1:0]     bl_q, bl_d;
    logic [bits-1:0]     br_q, br_d;
    logic [bits-1:0]     data_q, data_d;
    logic                start_q, start_d;
    logic                valid_q, valid_d;
    logic                fd_q, fd_d;

    // Sized to the full counter range so every column index is in bounds.
    logic [bits-1:0]     line_buf [2**col_bits];

    logic                accept;
    logic [col_bits-1:0] col_left;

    assign in_ready   = (state_q != EMIT);
    assign accept     = in_valid && in_ready;
    assign col_left   = col_q - 1'b1;
    assign data_out   = data_q;
    assign start      = start_q;
    assign out_valid  = valid_q;
    assign frame_done = fd_q;

    // Even-row line buffer: written once per pixel, never cleared.
    always_ff @(posedge clk_in) begin
        if (accept && state_q == FILL_TOP) begin
            line_buf[col_q] <= data_in;
        end
    end

    // State, counters, bottom-pixel holding registers and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL_TOP;
            col_q   <= '0;
            row_q   <= '0;
            e_q     <= '0;
            bl_q    <= '0;
            br_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            e_q     <= e_d;
            bl_q    <= bl_d;
            br_q    <= br_d;
            data_q  <= data_d;
            start_q <= start_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state and output decode.
    // The column counter is held at the odd column c throughout EMIT so that
    // line_buf[c-1]/line_buf[c] can be addressed. It only advances after the
    // last element. Each output is loaded one cycle ahead of its emit slot.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        e_d     = e_q;
        bl_d    = bl_q;
        br_d    = br_q;
        data_d  = data_q;
        start_d = 1'b0;
        valid_d = 1'b0;
        fd_d    = 1'b0;

        case (state_q)
            FILL_TOP: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                        state_d = FILL_BOT;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            FILL_BOT: begin
                if (accept) begin
                    if (!col_q[0]) begin
                        bl_d  = data_in;
                        col_d = col_q + 1'b1;
                    end else begin
                        br_d    = data_in;
                        state_d = EMIT;
                        e_d     = 2'd0;
                        data_d  = line_buf[col_left];
                        start_d = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end

            EMIT: begin
                case (e_q)
                    2'd0: begin
                        data_d  = line_buf[col_q];
                        valid_d = 1'b1;
                        e_d     = 2'd1;
                    end
                    2'd1: begin
                        data_d  = bl_q;
                        valid_d = 1'b1;
                        e_d     = 2'd2;
                    end
                    2'd2: begin
                        data_d  = br_q;
                        valid_d = 1'b1;
                        e_d     = 2'd3;
                        fd_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end
                    default: begin
                        e_d = 2'd0;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                            state_d = FILL_TOP;
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = FILL_BOT;
                        end
                    end
                endcase
            end

            default: state_d = FILL_TOP;
        endcase
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder. The stimulus pushes the expected window
// elements and window maxima into per-instance queues. A negedge monitor pops
// and compares whenever out_valid is high. A 4x4 and an 8x8 instance are used.
module tb_pool_window_feeder;

    typedef struct packed {
        logic [15:0] d;
        logic        st;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] din0 = '0, din1 = '0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        rdy0, rdy1, st0, st1, ov0, ov1, fd0, fd1;
    logic [15:0] dout0, dout1;

    exp_t        q0[$], q1[$];
    logic [15:0] m0[$], m1[$];
    int          phase[2];
    logic [15:0] runmax[2];
    int          fdc0 = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pool_window_feeder #(.bits(16), .map_w(4), .map_h(4), .col_bits(2), .row_bits(2)) dut4 (
        .clk_in(clk), .rst_n(rst_n), .data_in(din0), .in_valid(v0), .in_ready(rdy0),
        .data_out(dout0), .start(st0), .out_valid(ov0), .frame_done(fd0));

    pool_window_feeder #(.bits(16), .map_w(8), .map_h(8), .col_bits(3), .row_bits(3)) dut8 (
        .clk_in(clk), .rst_n(rst_n), .data_in(din1), .in_valid(v1), .in_ready(rdy1),
        .data_out(dout1), .start(st1), .out_valid(ov1), .frame_done(fd1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int inst, input logic ov, input logic st, input logic fd,
                       input logic rdy, input logic [15:0] d);
        exp_t        e;
        logic [15:0] mx;
        if (!rst_n) begin
            chk($sformatf("rst_data%0d", inst), {16'h0, d}, 32'h0);
            chk($sformatf("rst_flags%0d", inst), {29'h0, ov, st, fd}, 32'h0);
            chk($sformatf("rst_ready%0d", inst), {31'h0, rdy}, 32'h1);
            phase[inst]  = 0;
            runmax[inst] = '0;
        end else begin
            chk($sformatf("ready_vs_emit%0d", inst), {31'h0, rdy}, {31'h0, !ov});
            if (ov) begin
                if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected_elem%0d", inst), {16'h0, d}, 32'hFFFF_FFFF);
                end else begin
                    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("elem%0d", inst), {16'h0, d}, {16'h0, e.d});
                    chk($sformatf("start%0d", inst), {31'h0, st}, {31'h0, e.st});
                    chk($sformatf("frame_done%0d", inst), {31'h0, fd}, {31'h0, e.fd});
                end
                if (phase[inst] == 0 || d > runmax[inst]) runmax[inst] = d;
                phase[inst]++;
                if (phase[inst] == 4) begin
                    if ((inst == 0 && m0.size() == 0) || (inst == 1 && m1.size() == 0)) begin
                        chk($sformatf("unexpected_max%0d", inst), {16'h0, runmax[inst]}, 32'hFFFF_FFFF);
                    end else begin
                        mx = (inst == 0) ? m0.pop_front() : m1.pop_front();
                        chk($sformatf("pool_max%0d", inst), {16'h0, runmax[inst]}, {16'h0, mx});
                    end
                    phase[inst] = 0;
                end
                if (inst == 0 && fd) fdc0++;
            end else if (phase[inst] != 0) begin
                chk($sformatf("window_gap%0d", inst), phase[inst], 0);
                phase[inst] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, st0, fd0, rdy0, dout0);
        mon(1, ov1, st1, fd1, rdy1, dout1);
    end

    // Drive one pixel; caller is positioned just after a rising edge.
    task automatic send(input int inst, input logic [15:0] val, input bit gap);
        logic rdy;
        bit   done = 0;
        if (gap) begin
            if (inst == 0) v0 = 1'b0; else v1 = 1'b0;
            @(posedge clk); #1;
        end
        if (inst == 0) begin din0 = val; v0 = 1'b1; end
        else begin din1 = val; v1 = 1'b1; end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            rdy = (inst == 0) ? rdy0 : rdy1;
            @(posedge clk);
            if (rdy) done = 1;
        end
        #1;
        if (!done) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int inst);
        if (inst == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain(input int inst);
        bit ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge clk);
            if (inst == 0) ok = (q0.size() == 0 && m0.size() == 0 && phase[0] == 0);
            else           ok = (q1.size() == 0 && m1.size() == 0 && phase[1] == 0);
        end
        #1;
        if (!ok) chk("drain_timeout", 32'h0, 32'h1);
    endtask

    // Push a hand-written 16-element stream for the 4x4 instance.
    task automatic push_list16(input logic [15:0] el [16], input logic [15:0] mx [4]);
        for (int i = 0; i < 16; i++) q0.push_back('{d: el[i], st: (i % 4 == 0), fd: (i == 15)});
        for (int i = 0; i < 4; i++) m0.push_back(mx[i]);
    endtask

    // Window-order reference for an arbitrary row-major frame.
    task automatic push_frame(input int inst, input int w, input int h, input logic [15:0] pix [64]);
        logic [15:0] el [4];
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                el[0] = pix[r*w + c];
                el[1] = pix[r*w + c + 1];
                el[2] = pix[(r+1)*w + c];
                el[3] = pix[(r+1)*w + c + 1];
                for (int k = 0; k < 4; k++) begin
                    if (inst == 0) q0.push_back('{d: el[k], st: (k == 0), fd: (k == 3 && r == h-2 && c == w-2)});
                    else           q1.push_back('{d: el[k], st: (k == 0), fd: (k == 3 && r == h-2 && c == w-2)});
                end
            end
        end
    endtask

    logic [15:0] asc_el [16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};
    logic [15:0] asc_mx [4]  = '{6, 8, 14, 16};
    logic [15:0] dsc_el [16] = '{16, 15, 12, 11, 14, 13, 10, 9, 8, 7, 4, 3, 6, 5, 2, 1};
    logic [15:0] dsc_mx [4]  = '{16, 14, 8, 6};
    logic [15:0] mx8 [16]    = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};
    logic [15:0] pix [64];
    int          fd_before;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        phase[0] = 0; phase[1] = 0;
        runmax[0] = '0; runmax[1] = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ascending 4x4 frame, in_valid held high.
        push_list16(asc_el, asc_mx);
        for (int i = 1; i <= 16; i++) send(0, 16'(i), 0);
        idle(0);
        drain(0);
        chk("fd_count_first", fdc0, 1);

        // Back-to-back frames: descending then ascending, no idle between.
        fd_before = fdc0;
        push_list16(dsc_el, dsc_mx);
        push_list16(asc_el, asc_mx);
        for (int i = 16; i >= 1; i--) send(0, 16'(i), 0);
        for (int i = 1; i <= 16; i++) send(0, 16'(i), 0);
        idle(0);
        drain(0);
        chk("fd_count_b2b", fdc0 - fd_before, 2);

        // Reset in the middle of the first window of a frame.
        for (int i = 1; i <= 6; i++) send(0, 16'(i), 0);
        idle(0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        push_list16(asc_el, asc_mx);
        for (int i = 1; i <= 16; i++) send(0, 16'(i), 0);
        idle(0);
        drain(0);

        // Full-width extremes: 0xFFFF / 0x0000 alternating.
        for (int i = 0; i < 16; i++) pix[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
        push_frame(0, 4, 4, pix);
        for (int i = 0; i < 4; i++) m0.push_back(16'hFFFF);
        for (int i = 0; i < 16; i++) send(0, pix[i], 0);
        idle(0);
        drain(0);

        // 8x8 frame of 0..63 with random in_valid gaps.
        for (int i = 0; i < 64; i++) pix[i] = 16'(i);
        push_frame(1, 8, 8, pix);
        for (int i = 0; i < 16; i++) m1.push_back(mx8[i]);
        for (int i = 0; i < 64; i++) send(1, pix[i], ($urandom_range(0, 9) < 3));
        idle(1);
        drain(1);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Front-end for the serial max-pool stage. It accepts a row-major feature-map stream and buffers one even row in a line buffer. For each 2x2 window it then drives the four window elements on four consecutive cycles, with a one-cycle `start` on the first element. This is exactly the serial sequence the max-pool block consumes, and each window's max appears at the pool output one cycle after the fourth element.

## Interface
- `bits`, 16, data word width
- `map_w`, 8, feature-map width in pixels; even, ≥2
- `map_h`, 8, feature-map height in rows; even, ≥2
- `col_bits`, 3, column counter width; must satisfy 2^col_bits ≥ map_w
- `row_bits`, 3, row counter width; must satisfy 2^row_bits ≥ map_h

- `clk_in`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_in`  in  bits  input pixel, unsigned
- `in_valid`  in  1  `data_in` is valid this cycle
- `in_ready`  out  1  block accepts `data_in` this cycle
- `data_out`  out  bits  window element to the pool stage (registered)
- `start`  out  1  one-cycle pulse with the first (top-left) element of each window
- `out_valid`  out  1  high on all four element cycles of a window
- `frame_done`  out  1  one-cycle pulse with the last element of the last window of a frame

## Operation
- A pixel is accepted when `in_valid && in_ready`. Pixels arrive row-major, column 0 first.
- Counters:
  - `col` runs 0..map_w-1 and wraps to 0.
  - `row` runs 0..map_h-1; it increments on column wrap and wraps to 0 after the last row.
- FSM states: FILL_TOP, FILL_BOT, EMIT.
  - FILL_TOP (even row):
    - `in_ready`=1.
    - Each accepted pixel is written to `line_buf[col]` (map_w x bits).
    - On accepting col=map_w-1, go to FILL_BOT.
  - FILL_BOT (odd row):
    - `in_ready`=1.
    - At even col, the accepted pixel is stored in the `bl` register.
    - At odd col, it is stored in the `br` register and the state goes to EMIT.
  - EMIT:
    - `in_ready`=0 for 4 cycles, driven by an emit index e = 0..3.
    - e=0: `line_buf[c-1]`; e=1: `line_buf[c]`; e=2: `bl`; e=3: `br`, where c is the odd column just accepted.
    - `start`=1 only at e=0; `out_valid`=1 for e = 0..3.
    - After e=3: return to FILL_BOT if the row is incomplete. Otherwise return to FILL_TOP, and the row advances by one (from the odd row to the next even row).
- `frame_done` = 1 at e=3 when the window is the last window of the last row (row=map_h-1, c=map_w-1). Row and col are then 0.
- Window order within a row pair is left to right; row pairs are processed top to bottom.
- `line_buf` is not cleared between rows. The next even row overwrites every entry before it is read again.
- `in_valid` low simply stalls; there is no timeout.
- No arithmetic is performed on data; values pass through unchanged.

## Timing
- Reset (async, `rst_n`=0):
  - State=FILL_TOP, col=row=e=0.
  - `data_out`=0, `start`=0, `out_valid`=0, `frame_done`=0.
  - `bl`=`br`=0.
  - `in_ready`=1, decoded combinationally from state.
- Reset asserted mid-window or mid-frame discards all partial data. After release, the next accepted pixel is treated as (row 0, col 0).
- Window emission relative to the accept cycle T of the bottom-right pixel:
  - `start`/TL at T+1, TR at T+2, BL at T+3, BR at T+4; all outputs are registered.
  - `in_ready`=0 during T+1..T+4 and =1 again at T+5.
  - The pool stage presents the window max at T+5.
- Emission is never interrupted: four consecutive element cycles with no gaps, as the pool stage requires.
- Throughput:
  - Even rows: 1 pixel/cycle.
  - Odd rows: 2 pixels per 6 cycles when `in_valid` is held high.
- `start` never rises within 4 cycles of the previous `start`.

## Test plan
- 4x4 map, pixels 1..16 row-major, `in_valid` held 1:
  - Element stream: 1,2,5,6 / 3,4,7,8 / 9,10,13,14 / 11,12,15,16, with `start` on 1, 3, 9, 11.
  - Downstream pool results: 6, 8, 14, 16.
  - `frame_done` coincides with element 16.
- Handshake on the same map: `in_ready` reads 0 for exactly 4 cycles after the accepts of 6, 8, 14 and 16, and 1 at all other times; no pixel is dropped or duplicated.
- Random `in_valid` gaps (~30% low) on an 8x8 map of values 0..63:
  - 16 windows emitted, each with 4 contiguous `out_valid` cycles.
  - Window maxima are 9,11,13,15,25,…,63.
- Back-to-back frames: two 4x4 frames of 16..1 then 1..16, with no idle between them. Windows of frame 2 match the first scenario, and `frame_done` pulses exactly twice.
- `rst_n` pulsed low after the 6th pixel of frame 1:
  - All outputs go to 0 immediately.
  - After release, a fresh 4x4 frame 1..16 yields pool results 6, 8, 14, 16.
- Value extremes: pixels 0xFFFF and 0x0000 alternating; the element stream reproduces the inputs exactly, checking that the full `bits` width passes through.
